// File: rtl/spi_slave_core.sv
// -----------------------------------------------------------------------------
// spi_slave_core
//
// Purpose:
//   Parametrised SPI slave. SCLK, CS and MOSI are brought into the system
//   clock domain through synchroniser chains. Edges are detected on the
//   synchronised SCLK and turned into sample/shift strobes for the selected
//   CPOL/CPHA mode. Received words go to the fabric over a valid/ready
//   interface. Transmit words come from the fabric into a one-word holding
//   register. Several words can be exchanged back to back inside a single
//   CS frame.
//
// Ports:
//   clk          system clock; SCLK must run no faster than clk/8
//   reset        synchronous, active-high
//   tx_data      next word to transmit on MISO
//   tx_valid     tx_data is valid
//   tx_ready     holding register is empty and can accept tx_data
//   rx_data      last complete word received on MOSI
//   rx_valid     rx_data is valid; held until accepted with rx_ready
//   rx_ready     consumer accepts rx_data
//   rx_overrun   1-cycle pulse: a word completed while rx_valid was still set
//   tx_underrun  1-cycle pulse: a word started with nothing to send
//   frame_abort  1-cycle pulse: CS rose in the middle of a word
//   busy         synchronised CS is low (frame in progress)
//   sclk         SPI clock from the pad (asynchronous)
//   CS           chip select from the pad, active low (asynchronous)
//   MOSI         master-out data from the pad (asynchronous)
//   MISO         slave-out data to the pad; 0 whenever miso_oe is 0
//   miso_oe      MISO pad drive enable (1 = drive)
// -----------------------------------------------------------------------------
module spi_slave_core #(
    parameter int DATA_WIDTH  = 8,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter bit LSB_FIRST   = 1'b1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  rx_overrun,
    output logic                  tx_underrun,
    output logic                  frame_abort,
    output logic                  busy,
    input  logic                  sclk,
    input  logic                  CS,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic                  miso_oe
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Synchronisers and the edge-detect stage
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;

    logic ss, cs_s, mosi_s;
    logic leading, trailing;

    logic sclk_prev_q, sclk_prev_d;
    logic cs_prev_q, cs_prev_d;
    logic sample_q, sample_d;
    logic shift_q, shift_d;
    logic cs_fall_q, cs_fall_d;
    logic cs_rise_q, cs_rise_d;
    logic mosi_bit_q, mosi_bit_d;

    assign ss     = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // The strobes are registered once more after edge detection. Together
    // with the synchroniser depth, the core therefore acts SYNC_STAGES+2
    // clocks after a raw pad edge. MOSI travels alongside the strobes; the
    // master holds it stable for at least half an SCLK period.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], CS};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};

        sclk_prev_d = ss;
        cs_prev_d   = cs_s;

        leading  = (sclk_prev_q == CPOL) && (ss != CPOL);
        trailing = (sclk_prev_q != CPOL) && (ss == CPOL);

        sample_d   = CPHA ? trailing : leading;
        shift_d    = CPHA ? leading : trailing;
        cs_fall_d  = cs_prev_q && !cs_s;
        cs_rise_d  = !cs_prev_q && cs_s;
        mosi_bit_d = mosi_s;
    end

    // -------------------------------------------------------------------------
    // Frame state, shifters, holding register and flags
    // -------------------------------------------------------------------------
    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]   rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    rx_overrun_q, rx_overrun_d;
    logic                    tx_underrun_q, tx_underrun_d;
    logic                    frame_abort_q, frame_abort_d;
    logic [DATA_WIDTH-1:0]   hold_q, hold_d;
    logic                    hold_full_q, hold_full_d;
    logic [DATA_WIDTH-1:0]   tx_shift_q, tx_shift_d;
    logic                    miso_q, miso_d;
    logic                    miso_oe_q, miso_oe_d;

    logic                    do_load;
    logic [DATA_WIDTH-1:0]   load_word;

    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
        return LSB_FIRST ? w[0] : w[DATA_WIDTH-1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w);
        return LSB_FIRST ? {1'b0, w[DATA_WIDTH-1:1]} : {w[DATA_WIDTH-2:0], 1'b0};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] w,
                                                       input logic b);
        return LSB_FIRST ? {b, w[DATA_WIDTH-1:1]} : {w[DATA_WIDTH-2:0], b};
    endfunction

    // Next-state logic. A word load happens at frame start and after the
    // last sample of every word. The load takes the holding register if it
    // is full. Otherwise it takes tx_data directly when tx_valid is high that
    // cycle, and in that case the holding register write is cancelled. If
    // neither is available, zeros are sent and an underrun is flagged.
    // In CPHA=0 the first bit of a word must be on MISO before the first
    // sample edge, so it is driven at load time. The shift edge right after
    // a word's last sample (bit count back at 0) is then skipped.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        rx_shift_d    = rx_shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        rx_overrun_d  = 1'b0;
        tx_underrun_d = 1'b0;
        frame_abort_d = 1'b0;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        tx_shift_d    = tx_shift_q;
        miso_d        = miso_q;
        miso_oe_d     = miso_oe_q;
        do_load       = 1'b0;
        load_word     = '0;

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (cs_fall_q) begin
                    state_d    = ACTIVE;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                    miso_oe_d  = 1'b1;
                    do_load    = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise_q) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    miso_d    = 1'b0;
                    miso_oe_d = 1'b0;
                    if (bit_cnt_q != '0) begin
                        frame_abort_d = 1'b1;
                    end
                end else begin
                    if (sample_q) begin
                        rx_shift_d = shift_in(rx_shift_q, mosi_bit_q);
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_d    = '0;
                            rx_data_d    = rx_shift_d;
                            rx_valid_d   = 1'b1;
                            rx_overrun_d = rx_valid_q && !rx_ready;
                            do_load      = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                    if (shift_q && (CPHA || (bit_cnt_q != '0))) begin
                        miso_d     = first_bit(tx_shift_q);
                        tx_shift_d = shift_out(tx_shift_q);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (do_load) begin
            if (hold_full_q) begin
                load_word   = hold_q;
                hold_full_d = 1'b0;
            end else if (tx_valid) begin
                load_word   = tx_data;
                hold_full_d = 1'b0;
            end else begin
                tx_underrun_d = 1'b1;
            end
            if (CPHA) begin
                tx_shift_d = load_word;
            end else begin
                miso_d     = first_bit(load_word);
                tx_shift_d = shift_out(load_word);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync_q   <= {SYNC_STAGES{CPOL}};
            cs_sync_q     <= {SYNC_STAGES{1'b1}};
            mosi_sync_q   <= '0;
            sclk_prev_q   <= CPOL;
            cs_prev_q     <= 1'b1;
            sample_q      <= 1'b0;
            shift_q       <= 1'b0;
            cs_fall_q     <= 1'b0;
            cs_rise_q     <= 1'b0;
            mosi_bit_q    <= 1'b0;
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            rx_shift_q    <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_overrun_q  <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_abort_q <= 1'b0;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            tx_shift_q    <= '0;
            miso_q        <= 1'b0;
            miso_oe_q     <= 1'b0;
        end else begin
            sclk_sync_q   <= sclk_sync_d;
            cs_sync_q     <= cs_sync_d;
            mosi_sync_q   <= mosi_sync_d;
            sclk_prev_q   <= sclk_prev_d;
            cs_prev_q     <= cs_prev_d;
            sample_q      <= sample_d;
            shift_q       <= shift_d;
            cs_fall_q     <= cs_fall_d;
            cs_rise_q     <= cs_rise_d;
            mosi_bit_q    <= mosi_bit_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_shift_q    <= rx_shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            rx_overrun_q  <= rx_overrun_d;
            tx_underrun_q <= tx_underrun_d;
            frame_abort_q <= frame_abort_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            tx_shift_q    <= tx_shift_d;
            miso_q        <= miso_d;
            miso_oe_q     <= miso_oe_d;
        end
    end

    assign tx_ready    = !hold_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_overrun  = rx_overrun_q;
    assign tx_underrun = tx_underrun_q;
    assign frame_abort = frame_abort_q;
    assign busy        = (state_q == ACTIVE);
    assign MISO        = miso_q;
    assign miso_oe     = miso_oe_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_core
//
// Purpose:
//   Directed bench for spi_slave_core. Four instances cover the four SPI
//   modes: index 0 = mode 0 LSB first, 1 = mode 1 MSB first,
//   2 = mode 2 LSB first, 3 = mode 3 MSB first. A behavioural SPI master
//   drives one instance at a time. The other instances keep CS high.
// -----------------------------------------------------------------------------
module tb_spi_slave_core;

    localparam int HALF = 80;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       rx_ready;
    logic [3:0] tx_valid_v;
    logic [3:0] sclk_v;
    logic [3:0] cs_v;
    logic [3:0] mosi_v;

    wire  [3:0] tx_ready_v;
    wire  [3:0] rx_valid_v;
    wire  [3:0] rx_ovr_v;
    wire  [3:0] tx_unr_v;
    wire  [3:0] abort_v;
    wire  [3:0] busy_v;
    wire  [3:0] miso_v;
    wire  [3:0] oe_v;
    wire  [7:0] rx_data_v [4];

    int n_checks = 0;
    int n_fail   = 0;
    int ovr_cnt [4] = '{0, 0, 0, 0};
    int unr_cnt [4] = '{0, 0, 0, 0};
    int abt_cnt [4] = '{0, 0, 0, 0};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_core #(
            .DATA_WIDTH (8),
            .CPOL       (g >= 2),
            .CPHA       (g % 2 == 1),
            .LSB_FIRST  (g % 2 == 0),
            .SYNC_STAGES(2)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .tx_data    (tx_data),
            .tx_valid   (tx_valid_v[g]),
            .tx_ready   (tx_ready_v[g]),
            .rx_data    (rx_data_v[g]),
            .rx_valid   (rx_valid_v[g]),
            .rx_ready   (rx_ready),
            .rx_overrun (rx_ovr_v[g]),
            .tx_underrun(tx_unr_v[g]),
            .frame_abort(abort_v[g]),
            .busy       (busy_v[g]),
            .sclk       (sclk_v[g]),
            .CS         (cs_v[g]),
            .MOSI       (mosi_v[g]),
            .MISO       (miso_v[g]),
            .miso_oe    (oe_v[g])
        );
    end

    // The status pulses last one clock, so they are tallied here and the
    // directed steps compare the tallies before and after each action.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rx_ovr_v[i]) ovr_cnt[i] <= ovr_cnt[i] + 1;
            if (tx_unr_v[i]) unr_cnt[i] <= unr_cnt[i] + 1;
            if (abort_v[i])  abt_cnt[i] <= abt_cnt[i] + 1;
        end
    end

    function automatic logic cpolOf(input int i);
        return (i >= 2);
    endfunction

    function automatic logic cphaOf(input int i);
        return (i % 2 == 1);
    endfunction

    function automatic logic lsbOf(input int i);
        return (i % 2 == 0);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Master side of one word: nbits clock periods on instance i. MISO is
    // captured at the master's sample edge into its bit position.
    task automatic applyStimulus(input int i, input logic [7:0] mosi_word,
                                 input int nbits, output logic [7:0] miso_word);
        int idx;
        miso_word = '0;
        for (int b = 0; b < nbits; b++) begin
            idx = lsbOf(i) ? b : 7 - b;
            if (!cphaOf(i)) begin
                mosi_v[i] = mosi_word[idx];
                #(HALF);
                sclk_v[i] = ~cpolOf(i);
                miso_word[idx] = miso_v[i];
                #(HALF);
                sclk_v[i] = cpolOf(i);
            end else begin
                sclk_v[i] = ~cpolOf(i);
                mosi_v[i] = mosi_word[idx];
                #(HALF);
                sclk_v[i] = cpolOf(i);
                miso_word[idx] = miso_v[i];
                #(HALF);
            end
        end
    endtask

    task automatic loadTx(input int i, input logic [7:0] d);
        tx_data       = d;
        tx_valid_v[i] = 1'b1;
        #10;
        tx_valid_v[i] = 1'b0;
    endtask

    task automatic csLow(input int i);
        cs_v[i] = 1'b0;
        #(HALF);
    endtask

    task automatic csHigh(input int i);
        #(HALF);
        cs_v[i] = 1'b1;
        #(HALF);
    endtask

    task automatic acceptRx();
        rx_ready = 1'b1;
        #10;
        rx_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] mw;
        logic [7:0] mw2;
        int u0, o0, a0;

        reset      = 1'b1;
        tx_data    = '0;
        rx_ready   = 1'b0;
        tx_valid_v = '0;
        sclk_v     = 4'b1100;
        cs_v       = 4'b1111;
        mosi_v     = '0;

        @(negedge clk);
        #30;
        checkOutput("reset_rx_data", rx_data_v[0], 8'h00);
        checkOutput("reset_rx_valid", rx_valid_v[0], 1'b0);
        checkOutput("reset_tx_ready", tx_ready_v, 4'hF);
        checkOutput("reset_miso", miso_v, 4'h0);
        checkOutput("reset_oe", oe_v, 4'h0);
        checkOutput("reset_busy", busy_v, 4'h0);
        reset = 1'b0;
        #20;

        // Mode 0, LSB first: send 0xA5, receive 0x3C
        $display("[TB] basic mode 0 transfer");
        u0 = unr_cnt[0]; o0 = ovr_cnt[0]; a0 = abt_cnt[0];
        loadTx(0, 8'hA5);
        checkOutput("m0_tx_ready_full", tx_ready_v[0], 1'b0);
        csLow(0);
        checkOutput("m0_oe_on", oe_v[0], 1'b1);
        checkOutput("m0_busy_on", busy_v[0], 1'b1);
        checkOutput("m0_tx_ready_taken", tx_ready_v[0], 1'b1);
        checkOutput("m0_first_bit", miso_v[0], 1'b1);
        applyStimulus(0, 8'h3C, 8, mw);
        checkOutput("m0_miso_word", mw, 8'hA5);
        checkOutput("m0_rx_data", rx_data_v[0], 8'h3C);
        checkOutput("m0_rx_valid", rx_valid_v[0], 1'b1);
        csHigh(0);
        checkOutput("m0_oe_off", oe_v[0], 1'b0);
        checkOutput("m0_miso_off", miso_v[0], 1'b0);
        checkOutput("m0_busy_off", busy_v[0], 1'b0);
        checkOutput("m0_underrun_end", unr_cnt[0] - u0, 1);
        checkOutput("m0_overrun", ovr_cnt[0] - o0, 0);
        checkOutput("m0_abort", abt_cnt[0] - a0, 0);
        acceptRx();
        checkOutput("m0_rx_accept", rx_valid_v[0], 1'b0);

        // Remaining modes, same words
        for (int i = 1; i < 4; i++) begin
            $display("[TB] mode %0d transfer", i);
            loadTx(i, 8'hA5);
            csLow(i);
            applyStimulus(i, 8'h3C, 8, mw);
            checkOutput($sformatf("mode%0d_miso_word", i), mw, 8'hA5);
            checkOutput($sformatf("mode%0d_rx_data", i), rx_data_v[i], 8'h3C);
            checkOutput($sformatf("mode%0d_rx_valid", i), rx_valid_v[i], 1'b1);
            csHigh(i);
            checkOutput($sformatf("mode%0d_oe_off", i), oe_v[i], 1'b0);
        end
        acceptRx();

        // Two words in one frame, rx_ready held low
        $display("[TB] back-to-back words");
        u0 = unr_cnt[0]; o0 = ovr_cnt[0]; a0 = abt_cnt[0];
        loadTx(0, 8'h11);
        csLow(0);
        loadTx(0, 8'h22);
        checkOutput("b2b_tx_ready_full", tx_ready_v[0], 1'b0);
        applyStimulus(0, 8'h5A, 8, mw);
        checkOutput("b2b_miso_w1", mw, 8'h11);
        checkOutput("b2b_rx_w1", rx_data_v[0], 8'h5A);
        checkOutput("b2b_underrun_w1", unr_cnt[0] - u0, 0);
        checkOutput("b2b_tx_ready_reload", tx_ready_v[0], 1'b1);
        applyStimulus(0, 8'hC3, 8, mw2);
        checkOutput("b2b_miso_w2", mw2, 8'h22);
        checkOutput("b2b_rx_w2", rx_data_v[0], 8'hC3);
        checkOutput("b2b_rx_valid", rx_valid_v[0], 1'b1);
        checkOutput("b2b_overrun", ovr_cnt[0] - o0, 1);
        csHigh(0);
        checkOutput("b2b_underrun_end", unr_cnt[0] - u0, 1);
        checkOutput("b2b_abort", abt_cnt[0] - a0, 0);
        acceptRx();

        // Frame with nothing to send
        $display("[TB] underrun frame");
        u0 = unr_cnt[0];
        csLow(0);
        checkOutput("unr_pulse_start", unr_cnt[0] - u0, 1);
        applyStimulus(0, 8'h81, 8, mw);
        checkOutput("unr_miso_word", mw, 8'h00);
        checkOutput("unr_rx_data", rx_data_v[0], 8'h81);
        csHigh(0);
        checkOutput("unr_pulse_end", unr_cnt[0] - u0, 2);
        acceptRx();

        // tx_valid rises exactly on the CS-fall load cycle: bypass
        $display("[TB] bypass on CS fall");
        u0 = unr_cnt[0];
        tx_data = 8'h96;
        cs_v[0] = 1'b0;
        #30;
        tx_valid_v[0] = 1'b1;
        #10;
        tx_valid_v[0] = 1'b0;
        checkOutput("byp_underrun", unr_cnt[0] - u0, 0);
        checkOutput("byp_tx_ready", tx_ready_v[0], 1'b1);
        #(HALF);
        applyStimulus(0, 8'h4B, 8, mw);
        checkOutput("byp_miso_word", mw, 8'h96);
        checkOutput("byp_rx_data", rx_data_v[0], 8'h4B);
        csHigh(0);
        checkOutput("byp_underrun_end", unr_cnt[0] - u0, 1);
        acceptRx();

        // CS rises after 5 of 8 bits
        $display("[TB] partial word abort");
        a0 = abt_cnt[0];
        loadTx(0, 8'hF0);
        csLow(0);
        applyStimulus(0, 8'hFF, 5, mw);
        checkOutput("abt_miso_partial", mw, 8'h10);
        csHigh(0);
        checkOutput("abt_pulse", abt_cnt[0] - a0, 1);
        checkOutput("abt_rx_valid", rx_valid_v[0], 1'b0);
        checkOutput("abt_rx_data_kept", rx_data_v[0], 8'h4B);
        loadTx(0, 8'h5A);
        csLow(0);
        applyStimulus(0, 8'h69, 8, mw);
        csHigh(0);
        checkOutput("abt_next_miso", mw, 8'h5A);
        checkOutput("abt_next_rx_data", rx_data_v[0], 8'h69);
        checkOutput("abt_next_rx_valid", rx_valid_v[0], 1'b1);
        checkOutput("abt_next_no_pulse", abt_cnt[0] - a0, 1);

        // Reset in the middle of a word, rx_valid still pending
        $display("[TB] reset mid-word");
        a0 = abt_cnt[0];
        loadTx(0, 8'h77);
        csLow(0);
        applyStimulus(0, 8'h00, 3, mw);
        reset = 1'b1;
        #10;
        checkOutput("rst_rx_data", rx_data_v[0], 8'h00);
        checkOutput("rst_rx_valid", rx_valid_v[0], 1'b0);
        checkOutput("rst_tx_ready", tx_ready_v[0], 1'b1);
        checkOutput("rst_miso", miso_v[0], 1'b0);
        checkOutput("rst_oe", oe_v[0], 1'b0);
        checkOutput("rst_busy", busy_v[0], 1'b0);
        cs_v[0] = 1'b1;
        #50;
        reset = 1'b0;
        #50;
        checkOutput("rst_no_abort", abt_cnt[0] - a0, 0);
        loadTx(0, 8'hC5);
        csLow(0);
        applyStimulus(0, 8'h1E, 8, mw);
        csHigh(0);
        checkOutput("rst_next_miso", mw, 8'hC5);
        checkOutput("rst_next_rx_data", rx_data_v[0], 8'h1E);
        checkOutput("rst_next_rx_valid", rx_valid_v[0], 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
